data_mem_sync: RTL and testbench

DATA_MEM_SYNC -- requirements
Module: data_mem_sync

---
 rtl/data_mem_sync.sv | 125 ++++++++++++
 tb/tb_data_mem_sync.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sync.sv
// Single-port synchronous data memory with byte-lane writes,
// self-zeroing init sequence, range checking and 1-cycle reads.
module data_mem_sync #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   dout,
  output logic                err,
  output logic                init_done
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic               accept;
  logic               in_range;
  logic               init_last;
  logic [CNT_W-1:0]   idx;

  // Full-width compare so high address bits never alias into the array.
  assign in_range  = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  assign idx       = addr[CNT_W-1:0];
  assign init_last = (cnt_q == CNT_W'(DEPTH - 1));

  // Next-state, init counter, handshake outputs and accept decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready     = 1'b0;
    init_done = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      INIT: begin
        if (clr) begin
          cnt_d = '0;
        end else if (init_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        ready     = 1'b1;
        init_done = 1'b1;
        accept    = req && !clr;
        if (clr) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Response pulses and held read data for the next cycle.
  always_comb begin
    rvalid_d = accept && !we;
    err_d    = accept && !in_range;
    dout_d   = dout_q;
    if (accept && !we) begin
      dout_d = in_range ? mem_q[idx] : '0;
    end
  end

  // FSM and response registers; reset kills any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Storage array: zero-fill during init, byte-lane writes when idle.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (accept && we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign dout   = dout_q;

endmodule

// File: tb/tb_data_mem_sync.sv
// Randomized and directed bench for data_mem_sync against
// an array-based reference model of the memory behaviour.
module tb_data_mem_sync;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] din;
  logic [1:0]  be;
  logic        ready;
  logic        rvalid;
  logic [15:0] dout;
  logic        err;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [64];
  int          init_left;
  logic        exp_rvalid;
  logic        exp_err;
  logic        exp_ready;
  logic [15:0] exp_dout;

  data_mem_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .be        (be),
    .ready     (ready),
    .rvalid    (rvalid),
    .dout      (dout),
    .err       (err),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    init_left  = 64;
    exp_rvalid = 1'b0;
    exp_err    = 1'b0;
    exp_ready  = 1'b0;
    exp_dout   = 16'h0000;
    for (int i = 0; i < 64; i++) m_mem[i] = 16'h0000;
  endtask

  // Drive one cycle from a negedge, predict the response, land on next negedge.
  task automatic step(input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] b,
                      input logic c);
    logic acc;
    req = r; we = w; addr = a; din = d; be = b; clr = c;
    acc = (init_left == 0) && r && !c;
    exp_rvalid = 1'b0;
    exp_err    = 1'b0;
    if (acc) begin
      if (w) begin
        if (a < 16'd64) begin
          for (int i = 0; i < 2; i++)
            if (b[i]) m_mem[a[5:0]][8*i +: 8] = d[8*i +: 8];
        end else begin
          exp_err = 1'b1;
        end
      end else begin
        exp_rvalid = 1'b1;
        exp_err    = (a >= 16'd64);
        exp_dout   = (a < 16'd64) ? m_mem[a[5:0]] : 16'h0000;
      end
    end
    if (c) begin
      init_left = 64;
      for (int i = 0; i < 64; i++) m_mem[i] = 16'h0000;
    end else if (init_left > 0) begin
      init_left--;
    end
    exp_ready = (init_left == 0);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    int cycles;
    rst_n = 1'b0; clr = 0; req = 0; we = 0; addr = 0; din = 0; be = 0;
    model_reset();
    #3;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h exp 0000", dout); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", init_done); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    while (!ready && cycles < 200) begin
      step(1'b1, 1'b0, 16'd3, 16'h0, 2'b11, 1'b0);
      cycles++;
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL init_rvalid got %b exp 0", rvalid); end
    end
    checks++; if (cycles !== 64) begin errors++; $display("FAIL init_len got %0d exp 64", cycles); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b exp 1", init_done); end
    for (int a = 0; a < 64; a++) begin
      step(1'b1, 1'b0, 16'(a), 16'($urandom), 2'($urandom), 1'b0);
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL zero_rvalid a=%0d got %b exp 1", a, rvalid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err a=%0d got %b exp 0", a, err); end
      checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL zero_dout a=%0d got %h exp 0000", a, dout); end
    end
  endtask

  task automatic test_byte_lanes();
    step(1'b1, 1'b1, 16'd5, 16'hABCD, 2'b11, 1'b0);
    checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL wr_pulse got rv=%b err=%b exp 0 0", rvalid, err); end
    step(1'b1, 1'b1, 16'd5, 16'h1200, 2'b10, 1'b0);
    step(1'b1, 1'b0, 16'd5, 16'h0000, 2'b00, 1'b0);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL lane_rvalid got %b exp 1", rvalid); end
    checks++; if (dout !== 16'h12CD) begin errors++; $display("FAIL lane_dout got %h exp 12cd", dout); end
    step(1'b0, 1'b0, 16'd5, 16'h0000, 2'b00, 1'b0);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b exp 0", rvalid); end
    checks++; if (dout !== 16'h12CD) begin errors++; $display("FAIL dout_hold got %h exp 12cd", dout); end
  endtask

  task automatic test_out_of_range();
    step(1'b1, 1'b1, 16'd64, 16'hFFFF, 2'b11, 1'b0);
    checks++; if (err !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL oor_wr got err=%b rv=%b exp 1 0", err, rvalid); end
    step(1'b1, 1'b0, 16'd64, 16'h0, 2'b00, 1'b0);
    checks++; if (err !== 1'b1 || rvalid !== 1'b1) begin errors++; $display("FAIL oor_rd64 got err=%b rv=%b exp 1 1", err, rvalid); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL oor_rd64_dout got %h exp 0000", dout); end
    step(1'b1, 1'b0, 16'h8005, 16'h0, 2'b00, 1'b0);
    checks++; if (err !== 1'b1 || rvalid !== 1'b1) begin errors++; $display("FAIL oor_alias got err=%b rv=%b exp 1 1", err, rvalid); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL oor_alias_dout got %h exp 0000", dout); end
    step(1'b1, 1'b0, 16'd5, 16'h0, 2'b00, 1'b0);
    checks++; if (dout !== 16'h12CD || err !== 1'b0) begin errors++; $display("FAIL mem5_kept got %h err=%b exp 12cd 0", dout, err); end
  endtask

  task automatic test_back_to_back();
    int nrv;
    nrv = 0;
    step(1'b1, 1'b1, 16'd10, 16'h1111, 2'b11, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 16'd10, 16'h0, 2'($urandom), 1'b0);
      if (rvalid === 1'b1) nrv++;
      checks++; if (dout !== 16'h1111) begin errors++; $display("FAIL b2b_dout k=%0d got %h exp 1111", k, dout); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got %b exp 1", k, ready); end
    end
    checks++; if (nrv !== 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", nrv); end
  endtask

  task automatic test_clr();
    int low;
    step(1'b1, 1'b1, 16'd3, 16'h5A5A, 2'b11, 1'b0);
    step(1'b1, 1'b1, 16'd7, 16'h7777, 2'b11, 1'b1);
    checks++; if (ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL clr_drop got rdy=%b rv=%b err=%b exp 0 0 0", ready, rvalid, err);
    end
    low = 1;
    while (!ready && low < 200) begin
      step(1'($urandom), 1'($urandom), 16'($urandom_range(0, 70)), 16'($urandom), 2'b11, 1'b0);
      checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL clr_ignored got rv=%b err=%b exp 0 0", rvalid, err); end
      if (!ready) low++;
    end
    checks++; if (low !== 64) begin errors++; $display("FAIL clr_len got %0d exp 64", low); end
    for (int a = 0; a < 64; a++) begin
      step(1'b1, 1'b0, 16'(a), 16'h0, 2'b00, 1'b0);
      checks++; if (dout !== 16'h0000 || rvalid !== 1'b1) begin
        errors++; $display("FAIL clr_zero a=%0d got %h rv=%b exp 0000 1", a, dout, rvalid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int cycles;
    step(1'b1, 1'b1, 16'd20, 16'hBEEF, 2'b11, 1'b0);
    req = 1'b1; we = 1'b0; addr = 16'd20;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse got rv=%b err=%b exp 0 0", rvalid, err); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL rst_mid_dout got %h exp 0000", dout); end
    checks++; if (ready !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL rst_mid_rdy got %b %b exp 0 0", ready, init_done); end
    model_reset();
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    cycles = 0;
    while (!ready && cycles < 200) begin
      step(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
      cycles++;
    end
    checks++; if (cycles !== 64) begin errors++; $display("FAIL rst_mid_init got %0d exp 64", cycles); end
    step(1'b1, 1'b0, 16'd20, 16'h0, 2'b00, 1'b0);
    checks++; if (dout !== 16'h0000 || rvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_mem got %h rv=%b exp 0000 1", dout, rvalid); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 8) a = 16'($urandom_range(0, 63));
      else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(64, 70));
      else a = 16'($urandom);
      step(1'($urandom_range(0, 9) != 0), 1'($urandom), a, 16'($urandom),
           2'($urandom), 1'($urandom_range(0, 149) == 0));
      checks++; if (rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid n=%0d got %b exp %b", n, rvalid, exp_rvalid); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd_err n=%0d got %b exp %b", n, err, exp_err); end
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rnd_dout n=%0d got %h exp %h", n, dout, exp_dout); end
      checks++; if (ready !== exp_ready) begin errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, ready, exp_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_clr();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
